// File: rtl/frame_seq_ctrl_pkg.sv
// Shared definitions for the frame sequencer.
//
// Contents:
//   state_t           - controller state encoding (IDLE, LOAD, SCAN, DONE).
//   FRAME_BYTES, HDR_BYTES, ROW_STRIDE, ACT_W, ACT_H
//                     - default geometry of one stored BMP frame.
//   ACT_PIXELS        - number of active bytes swept per frame.
//   ROW_SKIP          - read-address increment when stepping from the last
//                       active byte of a row to the first active byte of the next.
//   toAddr()          - narrows an integer constant to the 16-bit address width.
package frame_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAME_BYTES = 36300;
  localparam int HDR_BYTES   = 3330;
  localparam int ROW_STRIDE  = 330;
  localparam int ACT_W       = 300;
  localparam int ACT_H       = 100;

  localparam int ACT_PIXELS  = ACT_W * ACT_H;
  localparam int ROW_SKIP    = ROW_STRIDE - ACT_W + 1;

  localparam int ADDR_W      = 16;
  localparam int COORD_W     = 10;

  function automatic logic [ADDR_W-1:0] toAddr(input int value);
    return value[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/frame_seq_ctrl_scan_addr_gen.sv
// scan_addr_gen: read-side address generator for the active picture window.
//
// Walks the window row by row. The read address is built incrementally:
// +1 inside a row, +ROW_SKIP at the row end, so no multiplier is needed.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset, clears everything to 0
//   clear     in   load the start-of-window position (x=0, y=0, addr=HDR_BYTES,
//                  index=0); has priority over step
//   step      in   advance one active byte
//   xPos      out  current column 0..ACT_W-1
//   yPos      out  current row    0..ACT_H-1
//   rdAddr    out  buffer address of (xPos, yPos)
//   outIndex  out  linear active-pixel index of (xPos, yPos)
//   lastPix   out  current position is the bottom-right active byte
module scan_addr_gen
  import frame_seq_ctrl_pkg::*;
#(
  parameter int HDR_BYTES = frame_seq_ctrl_pkg::HDR_BYTES,
  parameter int ACT_W     = frame_seq_ctrl_pkg::ACT_W,
  parameter int ACT_H     = frame_seq_ctrl_pkg::ACT_H,
  parameter int ROW_SKIP  = frame_seq_ctrl_pkg::ROW_SKIP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] xPos,
  output logic [COORD_W-1:0] yPos,
  output logic [ADDR_W-1:0]  rdAddr,
  output logic [ADDR_W-1:0]  outIndex,
  output logic               lastPix
);

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(ACT_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(ACT_H - 1);
  localparam logic [ADDR_W-1:0]  ADDR_BASE = ADDR_W'(HDR_BYTES);
  localparam logic [ADDR_W-1:0]  ADDR_SKIP = ADDR_W'(ROW_SKIP);

  logic rowEnd;
  logic colEnd;

  assign rowEnd  = (xPos == X_LAST);
  assign colEnd  = (yPos == Y_LAST);
  assign lastPix = rowEnd && colEnd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xPos     <= '0;
      yPos     <= '0;
      rdAddr   <= '0;
      outIndex <= '0;
    end else if (clear) begin
      xPos     <= '0;
      yPos     <= '0;
      rdAddr   <= ADDR_BASE;
      outIndex <= '0;
    end else if (step) begin
      outIndex <= outIndex + 16'd1;
      if (rowEnd) begin
        // Jump over the row padding straight to the next row's first byte.
        xPos   <= '0;
        yPos   <= colEnd ? '0 : yPos + 10'd1;
        rdAddr <= rdAddr + ADDR_SKIP;
      end else begin
        xPos   <= xPos + 10'd1;
        rdAddr <= rdAddr + 16'd1;
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: load-then-scan sequencer for the frame byte buffer.
//
// A start in IDLE begins a cycle: LOAD accepts exactly FRAME_BYTES source
// bytes and writes them to buffer addresses 0..FRAME_BYTES-1, SCAN then
// issues one buffer read per cycle over the ACT_W x ACT_H active window,
// DONE pulses done for one cycle and the controller returns to IDLE.
//
// Source handshake: a byte is transferred in every cycle where
// in_valid && in_ready are both high at the rising edge. in_ready depends
// only on the state (high for the whole of LOAD), never on in_valid, and
// in_valid may drop at any time, which simply stalls LOAD.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   begin a load+scan cycle (looked at only in IDLE)
//   in_valid     in   source byte valid
//   in_data      in   source byte
//   in_ready     out  byte accepted this cycle when in_valid is high
//   buf_wr_en    out  buffer write strobe (= handshake)
//   buf_wr_addr  out  buffer write address (byte count so far)
//   buf_wr_data  out  buffer write data (= in_data)
//   buf_rd_en    out  buffer read strobe, high every SCAN cycle
//   buf_rd_addr  out  buffer read address
//   out_index    out  linear active-pixel index of the current read
//   pix_valid    out  buffer read data valid (read strobe delayed one cycle)
//   px_out       out  column of the pixel whose data is valid
//   line_out     out  row of the pixel whose data is valid
//   busy         out  high outside IDLE
//   done         out  one-cycle pulse after the last read
//   dbgState     out  current controller state, for observation only
module frame_seq_ctrl
  import frame_seq_ctrl_pkg::*;
#(
  parameter int FRAME_BYTES = frame_seq_ctrl_pkg::FRAME_BYTES,
  parameter int HDR_BYTES   = frame_seq_ctrl_pkg::HDR_BYTES,
  parameter int ROW_STRIDE  = frame_seq_ctrl_pkg::ROW_STRIDE,
  parameter int ACT_W       = frame_seq_ctrl_pkg::ACT_W,
  parameter int ACT_H       = frame_seq_ctrl_pkg::ACT_H
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         buf_wr_en,
  output logic [15:0]  buf_wr_addr,
  output logic [7:0]   buf_wr_data,
  output logic         buf_rd_en,
  output logic [15:0]  buf_rd_addr,
  output logic [15:0]  out_index,
  output logic         pix_valid,
  output logic [9:0]   px_out,
  output logic [9:0]   line_out,
  output logic         busy,
  output logic         done,
  output state_t       dbgState
);

  localparam logic [ADDR_W-1:0] LAST_BYTE = toAddr(FRAME_BYTES - 1);

  state_t              state;
  state_t              nextState;
  logic [ADDR_W-1:0]   wrCnt;
  logic                handshake;
  logic                lastByte;
  logic                scanClear;
  logic                scanStep;
  logic [COORD_W-1:0]  scanX;
  logic [COORD_W-1:0]  scanY;
  logic                scanLast;

  assign handshake = in_valid && in_ready;
  assign lastByte  = (wrCnt == LAST_BYTE);
  // The read position is preset on the final write so that the first SCAN
  // cycle already presents HDR_BYTES / index 0.
  assign scanClear = handshake && lastByte;
  assign scanStep  = (state == SCAN);

  assign buf_wr_en   = handshake;
  assign buf_wr_addr = wrCnt;
  assign buf_wr_data = in_data;
  assign dbgState    = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = LOAD;
      LOAD: if (handshake && lastByte) nextState = SCAN;
      SCAN: if (scanLast) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode (Moore outputs; the write strobe is the handshake above)
  always_comb begin
    in_ready  = 1'b0;
    buf_rd_en = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: busy      = 1'b0;
      LOAD: in_ready  = 1'b1;
      SCAN: buf_rd_en = 1'b1;
      DONE: done      = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  // Write byte counter: restarts on an accepted start, steps per handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrCnt <= '0;
    end else if ((state == IDLE) && start) begin
      wrCnt <= '0;
    end else if (handshake) begin
      wrCnt <= wrCnt + 16'd1;
    end
  end

  scan_addr_gen #(
    .HDR_BYTES (HDR_BYTES),
    .ACT_W     (ACT_W),
    .ACT_H     (ACT_H),
    .ROW_SKIP  (ROW_STRIDE - ACT_W + 1)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    (scanClear),
    .step     (scanStep),
    .xPos     (scanX),
    .yPos     (scanY),
    .rdAddr   (buf_rd_addr),
    .outIndex (out_index),
    .lastPix  (scanLast)
  );

  // Read data arrives one cycle after the strobe, so the strobe and the
  // coordinates are delayed once to line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      px_out    <= '0;
      line_out  <= '0;
    end else begin
      pix_valid <= buf_rd_en;
      if (buf_rd_en) begin
        px_out   <= scanX;
        line_out <= scanY;
      end
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Testbench for frame_seq_ctrl.
//
// Two instances share the clock: dut 0 uses the default frame geometry and
// runs one complete frame; dut 1 uses a small geometry so that reset during
// a scan, reload and start-held-through-DONE fit in a short run.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_frame_seq_ctrl;
  import frame_seq_ctrl_pkg::*;

  localparam int NDUT      = 2;
  localparam int SM_FRAME  = 50;
  localparam int SM_HDR    = 8;
  localparam int SM_STRIDE = 9;
  localparam int SM_W      = 7;
  localparam int SM_H      = 4;

  localparam int P_FRAME  [NDUT] = '{FRAME_BYTES, SM_FRAME};
  localparam int P_HDR    [NDUT] = '{HDR_BYTES,   SM_HDR};
  localparam int P_STRIDE [NDUT] = '{ROW_STRIDE,  SM_STRIDE};
  localparam int P_W      [NDUT] = '{ACT_W,       SM_W};
  localparam int P_H      [NDUT] = '{ACT_H,       SM_H};

  string dn [NDUT] = '{"full", "small"};

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        rst      [NDUT];
  logic        start    [NDUT];
  logic        inValid  [NDUT];
  logic [7:0]  inData   [NDUT];
  logic        inReady  [NDUT];
  logic        wrEn     [NDUT];
  logic [15:0] wrAddr   [NDUT];
  logic [7:0]  wrData   [NDUT];
  logic        rdEn     [NDUT];
  logic [15:0] rdAddr   [NDUT];
  logic [15:0] outIndex [NDUT];
  logic        pixValid [NDUT];
  logic [9:0]  pxOut    [NDUT];
  logic [9:0]  lineOut  [NDUT];
  logic        busy     [NDUT];
  logic        done     [NDUT];
  state_t      dbgState [NDUT];

  frame_seq_ctrl dut_full (
    .clk(clk), .reset(rst[0]), .start(start[0]),
    .in_valid(inValid[0]), .in_data(inData[0]), .in_ready(inReady[0]),
    .buf_wr_en(wrEn[0]), .buf_wr_addr(wrAddr[0]), .buf_wr_data(wrData[0]),
    .buf_rd_en(rdEn[0]), .buf_rd_addr(rdAddr[0]), .out_index(outIndex[0]),
    .pix_valid(pixValid[0]), .px_out(pxOut[0]), .line_out(lineOut[0]),
    .busy(busy[0]), .done(done[0]), .dbgState(dbgState[0])
  );

  frame_seq_ctrl #(
    .FRAME_BYTES(SM_FRAME), .HDR_BYTES(SM_HDR), .ROW_STRIDE(SM_STRIDE),
    .ACT_W(SM_W), .ACT_H(SM_H)
  ) dut_small (
    .clk(clk), .reset(rst[1]), .start(start[1]),
    .in_valid(inValid[1]), .in_data(inData[1]), .in_ready(inReady[1]),
    .buf_wr_en(wrEn[1]), .buf_wr_addr(wrAddr[1]), .buf_wr_data(wrData[1]),
    .buf_rd_en(rdEn[1]), .buf_rd_addr(rdAddr[1]), .out_index(outIndex[1]),
    .pix_valid(pixValid[1]), .px_out(pxOut[1]), .line_out(lineOut[1]),
    .busy(busy[1]), .done(done[1]), .dbgState(dbgState[1])
  );

  // ---------------- checking ----------------
  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // ph: 0 idle, 1 loading, 2 scanning, 3 done cycle.
  // k: bytes accepted in this frame, n: reads issued in this frame.
  int ph [NDUT];
  int k  [NDUT];
  int n  [NDUT];
  int wrSeen   [NDUT];
  int rdSeen   [NDUT];
  int doneSeen [NDUT];
  // Expected pixel coordinates in flight: {dut, line, px}.
  logic [20:0] exp_q [$];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      ph[d] = 0; k[d] = 0; n[d] = 0;
      wrSeen[d] = 0; rdSeen[d] = 0; doneSeen[d] = 0;
    end
  end

  task automatic modelStep(input int d);
    int eAddr;
    bit havePix;
    logic [20:0] e;
    logic [9:0] ex, ey;
    if (rst[d]) begin
      ph[d] = 0; k[d] = 0; n[d] = 0;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i][20] == d[0]) exp_q.delete(i);
      return;
    end
    check({dn[d], ".busy"},     busy[d],    ph[d] != 0);
    check({dn[d], ".in_ready"}, inReady[d], ph[d] == 1);
    check({dn[d], ".wr_en"},    wrEn[d],    (ph[d] == 1) && inValid[d]);
    check({dn[d], ".rd_en"},    rdEn[d],    ph[d] == 2);
    check({dn[d], ".done"},     done[d],    ph[d] == 3);
    if (ph[d] == 1) begin
      check({dn[d], ".wr_addr"}, wrAddr[d], k[d]);
      if (inValid[d]) check({dn[d], ".wr_data"}, wrData[d], inData[d]);
    end
    if (ph[d] == 2) begin
      eAddr = P_HDR[d] + (n[d] % P_W[d]) + P_STRIDE[d] * (n[d] / P_W[d]);
      check({dn[d], ".rd_addr"},   rdAddr[d],   eAddr);
      check({dn[d], ".out_index"}, outIndex[d], n[d]);
      if (d == 0) begin
        if (n[d] == 0)     check("full.first_rd",   rdAddr[d], 3330);
        if (n[d] == 299)   check("full.row0_end",   rdAddr[d], 3629);
        if (n[d] == 300)   check("full.row1_start", rdAddr[d], 3660);
        if (n[d] == 29999) begin
          check("full.last_rd",    rdAddr[d],   36299);
          check("full.last_index", outIndex[d], 29999);
        end
      end else if (n[d] == 0) begin
        check("small.first_rd", rdAddr[d], SM_HDR);
      end
    end
    havePix = (exp_q.size() > 0) && (exp_q[0][20] == d[0]);
    check({dn[d], ".pix_valid"}, pixValid[d], havePix);
    if (havePix) begin
      e = exp_q.pop_front();
      check({dn[d], ".px_out"},   pxOut[d],   e[9:0]);
      check({dn[d], ".line_out"}, lineOut[d], e[19:10]);
      if (d == 0 && e[9:0] == 10'd299 && e[19:10] == 10'd99) begin
        check("full.last_pix_done", done[d], 1);
      end
    end
    if (wrEn[d]) wrSeen[d]++;
    if (rdEn[d]) rdSeen[d]++;
    if (done[d]) doneSeen[d]++;
    // Advance the model across the coming rising edge.
    case (ph[d])
      0: if (start[d]) begin ph[d] = 1; k[d] = 0; end
      1: if (inValid[d]) begin
           k[d]++;
           if (k[d] == P_FRAME[d]) begin ph[d] = 2; n[d] = 0; end
         end
      2: begin
           ex = 10'(n[d] % P_W[d]);
           ey = 10'(n[d] / P_W[d]);
           exp_q.push_back({d[0], ey, ex});
           n[d]++;
           if (n[d] == P_W[d] * P_H[d]) ph[d] = 3;
         end
      default: ph[d] = 0;
    endcase
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) modelStep(d);
  end

  // ---------------- driver tasks ----------------
  task automatic resetCheck(input int d);
    check({dn[d], ".rst.in_ready"},  inReady[d],  0);
    check({dn[d], ".rst.wr_en"},     wrEn[d],     0);
    check({dn[d], ".rst.wr_addr"},   wrAddr[d],   0);
    check({dn[d], ".rst.rd_en"},     rdEn[d],     0);
    check({dn[d], ".rst.rd_addr"},   rdAddr[d],   0);
    check({dn[d], ".rst.out_index"}, outIndex[d], 0);
    check({dn[d], ".rst.pix_valid"}, pixValid[d], 0);
    check({dn[d], ".rst.px_out"},    pxOut[d],    0);
    check({dn[d], ".rst.line_out"},  lineOut[d],  0);
    check({dn[d], ".rst.busy"},      busy[d],     0);
    check({dn[d], ".rst.done"},      done[d],     0);
    check({dn[d], ".rst.state"},     dbgState[d], IDLE);
  endtask

  task automatic clearCounts(input int d);
    wrSeen[d] = 0; rdSeen[d] = 0; doneSeen[d] = 0;
  endtask

  task automatic startPulse(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    check({dn[d], ".busy_after_start"},  busy[d],    1);
    check({dn[d], ".ready_after_start"}, inReady[d], 1);
  endtask

  // Feeds FRAME bytes (data = byte address) with gapPct% idle cycles.
  task automatic loadBytes(input int d, input int gapPct, input bit pulseStart);
    int sent = 0;
    int guard = 0;
    bit hs;
    while (sent < P_FRAME[d] && guard < 4 * P_FRAME[d]) begin
      inValid[d] = ($urandom_range(99) >= gapPct);
      inData[d]  = sent[7:0];
      start[d]   = pulseStart && (sent == P_FRAME[d] / 3);
      @(negedge clk);
      hs = inValid[d] && inReady[d];
      @(posedge clk); #1;
      if (hs) sent++;
      guard++;
    end
    inValid[d] = 1'b0;
    start[d]   = 1'b0;
    check({dn[d], ".bytes_sent"}, sent, P_FRAME[d]);
    check({dn[d], ".scan_entered"}, rdEn[d], 1);
  endtask

  // Runs the scan to its done pulse, keeping in_valid toggling (must be
  // refused). pulseAt >= 0 pulses start at that scan cycle; holdFrom >= 0
  // holds start high from that scan cycle onwards.
  task automatic waitDone(input int d, input int pulseAt, input int holdFrom);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < P_W[d] * P_H[d] + 10) begin
      inValid[d] = 1'($urandom_range(1));
      inData[d]  = 8'($urandom_range(255));
      if (pulseAt >= 0) start[d] = (cyc == pulseAt);
      if (holdFrom >= 0 && cyc >= holdFrom) start[d] = 1'b1;
      @(negedge clk);
      seen = done[d];
      @(posedge clk); #1;
      cyc++;
    end
    inValid[d] = 1'b0;
    if (holdFrom < 0) start[d] = 1'b0;
    check({dn[d], ".done_seen"},   seen, 1);
    check({dn[d], ".scan_cycles"}, cyc,  P_W[d] * P_H[d] + 1);
    check({dn[d], ".idle_busy"},   busy[d], 0);
    check({dn[d], ".idle_state"},  dbgState[d], IDLE);
  endtask

  task automatic frameCounts(input int d);
    check({dn[d], ".write_count"}, wrSeen[d],   P_FRAME[d]);
    check({dn[d], ".read_count"},  rdSeen[d],   P_W[d] * P_H[d]);
    check({dn[d], ".done_count"},  doneSeen[d], 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; inValid[d] = 1'b0; inData[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) resetCheck(d);

    // start while reset is held must not do anything
    for (int d = 0; d < NDUT; d++) start[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check({dn[d], ".start_in_reset"}, busy[d], 0);
      start[d] = 1'b0;
      rst[d]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) check({dn[d], ".idle_after_reset"}, busy[d], 0);

    // Full-size frame: light backpressure, start pulsed in LOAD and SCAN.
    clearCounts(0);
    startPulse(0);
    loadBytes(0, 5, 1);
    waitDone(0, 15000, -1);
    frameCounts(0);

    // Small frame aborted by reset in the middle of the scan.
    clearCounts(1);
    startPulse(1);
    loadBytes(1, 30, 0);
    g = 0;
    while (n[1] < 14 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("small.reached_mid_scan", n[1], 14);
    #1 rst[1] = 1'b1;
    #1;
    resetCheck(1);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("small.no_done_after_abort", doneSeen[1], 0);
    check("small.idle_after_abort", busy[1], 0);

    // Reload and full sweep; start held high through DONE.
    clearCounts(1);
    startPulse(1);
    loadBytes(1, 20, 1);
    waitDone(1, -1, 10);
    frameCounts(1);
    @(posedge clk); #1;
    start[1] = 1'b0;
    check("small.restart_on_held_start", busy[1], 1);

    // Back-to-back frame started by the held start.
    clearCounts(1);
    loadBytes(1, 0, 0);
    waitDone(1, 5, -1);
    frameCounts(1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
